sar_result_collector: RTL and testbench
=======================================

// Module: sar_result_collector
// PURPOSE
//  Receive end of the SAR logic's serial result stream. Samples the 1-bit decision DIGITAL_OUT once per
//  comparator strobe, assembles BIT_ADC decisions MSB-first into one parallel conversion word and buffers
//  words in a small FIFO. Words leave through a valid/ready handshake. Sits between the SAR logic and the
//  digital back end; runs on the same CLK (48 MHz) as the SAR logic, so it has no synchronisers.
// PARAMETERS
//  BIT_ADC     8   bits per conversion word (MSB decided first)
//  FIFO_DEPTH  4   word buffer entries; power of 2, >=2
//  CNT_W       16  width of the word counter (only with SAR_COLLECT_CNT_EN)
// PORTS
//  CLK          in   1        system clock, shared with SAR logic
//  RST          in   1        synchronous reset, active-high
//  COMP_CLK     in   1        comparator clock from SAR logic; its falling edge is the bit strobe
//  DIGITAL_OUT  in   1        serial decision from SAR logic; stable when COMP_CLK falls
//  SYNC         in   1        frame realign; the next strobe is taken as the MSB
//  DATA         out  BIT_ADC  head-of-FIFO word; bit BIT_ADC-1 is the first decision
//  DATA_VALID   out  1        DATA holds a word
//  DATA_READY   in   1        consumer accepts DATA when DATA_VALID & DATA_READY
//  OVF          out  1        sticky: a word was dropped because the FIFO was full
//  OVF_CLR      in   1        clears OVF
//  WORD_CNT     out  CNT_W    count of words pushed (only with SAR_COLLECT_CNT_EN)
// BEHAVIOUR
//  - Reset (RST=1 at a CLK edge): DATA=0, DATA_VALID=0, OVF=0, WORD_CNT=0, FIFO empty,
//    bit index=0, shift reg=0, COMP_CLK_d=0. Reset mid-word discards the partial word and the FIFO contents.
//  - Strobe: COMP_CLK_d registers COMP_CLK each cycle. STB = COMP_CLK_d & ~COMP_CLK. COMP_CLK rising edges
//    and level are ignored.
//  - On an STB cycle: shift <= {shift[BIT_ADC-2:0], DIGITAL_OUT}, then bit index increments.
//    At bit index BIT_ADC-1 the word {shift[BIT_ADC-2:0], DIGITAL_OUT} is pushed at that edge and the index
//    wraps to 0. No idle state: the collector is a bit counter plus a shift register.
//  - SYNC=1 takes priority: bit index<=0 and shift<=0. An STB in the same cycle is discarded.
//  - Latency: DATA_VALID rises 1 cycle after the push edge when the FIFO was empty. DATA is the registered
//    FIFO head.
//  - Pop when DATA_VALID & DATA_READY at an edge. DATA_READY is ignored while DATA_VALID=0. DATA and
//    DATA_VALID stay stable while DATA_VALID=1 and DATA_READY=0.
//  - Full: a push while full with no pop in the same cycle drops the new word and sets OVF.
//    Stored words are kept.
//  - Push and pop in the same cycle: both happen (full stays full, no OVF; empty cannot pop).
//  - OVF: OVF_CLR=1 clears it; a set in the same cycle as OVF_CLR wins (OVF stays 1).
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty come from the MSB compare.
//  - Nominal rate: one strobe per 6 CLK, one word per 48 CLK (1 MS/s). The block accepts strobes as often
//    as every 2nd cycle.
// CONFIGURATION
//  SAR_COLLECT_CNT_EN defined: WORD_CNT port present. It increments on every accepted push (not on drops),
//    wraps at 2^CNT_W and resets to 0 only on RST.
//  Macro undefined: WORD_CNT port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package sar_pkg: BIT_ADC default (8) and SAR_PHASES=6 (CLK cycles per decision),
//    also used by SAR logic and bench.
//  - Sub-module sar_collect_fifo: synchronous FIFO, params WIDTH/DEPTH, ports push/din/full/pop/dout/empty.
//  - Strobe detect, shift register, bit counter and OVF/WORD_CNT live in the top module.
// TESTING
//  1. SAR model at 6-CLK phases sends 1,0,1,0,0,1,0,1 -> DATA=8'hA5, DATA_VALID=1 one cycle after the
//     8th STB edge; DATA_READY=1 -> DATA_VALID=0 next cycle.
//  2. Back-to-back words 8'h00, 8'hFF, 8'h5A with DATA_READY=0 -> three entries; release ->
//     popped in order 00, FF, 5A; OVF=0.
//  3. DATA_READY=0, 5 words with FIFO_DEPTH=4 -> first 4 kept, OVF=1; OVF_CLR pulse -> OVF=0;
//     with SAR_COLLECT_CNT_EN WORD_CNT=4.
//  4. Full FIFO, 5th push in same cycle as pop -> no OVF, 5th word retained, contents = words 2..5.
//  5. SYNC after 3 bits, then 8 bits of 8'h3C -> DATA=8'h3C (partial bits discarded);
//     an STB coincident with SYNC is not counted.
//  6. RST asserted after 4 bits with 2 words queued -> next cycle DATA_VALID=0, DATA=0, OVF=0;
//     next 8 bits 8'h81 -> DATA=8'h81.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared SAR constants: decision word width and CLK cycles per decision, used by the
// SAR logic, the result collector and its bench.
package sar_pkg;

  localparam int unsigned SAR_BIT_ADC    = 8;
  localparam int unsigned SAR_PHASES     = 6;
  localparam int unsigned SAR_FIFO_DEPTH = 4;
  localparam int unsigned SAR_CNT_W      = 16;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sar_collect_fifo.sv
// Synchronous word FIFO with a registered head: dout/empty are flops that update one
// edge after a push into an empty buffer and hold steady while the consumer stalls.
module sar_collect_fifo
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_BIT_ADC,
  parameter int unsigned DEPTH = SAR_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = fifo_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             full_s, do_pop_s, do_push_s;

  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop & valid_q;
  // A pop frees the slot being written, so a full buffer still accepts a concurrent push.
  assign do_push_s = push & (~full_s | do_pop_s);

  // Next-state for storage, pointers and the presented head word.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Head is taken from the pre-edge write pointer: a fresh word shows one edge later.
    valid_d = (wr_ptr_q != rd_ptr_d);
    dout_d  = mem_q[rd_ptr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign full  = full_s;
  assign dout  = dout_q;
  assign empty = ~valid_q;

endmodule

// File: rtl/sar_result_collector.sv
// Assembles the SAR serial decisions (sampled on COMP_CLK falling edges) MSB-first into
// words and queues them for a valid/ready consumer. Define SAR_COLLECT_CNT_EN for WORD_CNT.
module sar_result_collector
  import sar_pkg::*;
#(
  parameter int unsigned BIT_ADC    = SAR_BIT_ADC,
  parameter int unsigned FIFO_DEPTH = SAR_FIFO_DEPTH
`ifdef SAR_COLLECT_CNT_EN
  ,
  parameter int unsigned CNT_W      = SAR_CNT_W
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               COMP_CLK,
  input  logic               DIGITAL_OUT,
  input  logic               SYNC,
  output logic [BIT_ADC-1:0] DATA,
  output logic               DATA_VALID,
  input  logic               DATA_READY,
  output logic               OVF,
  input  logic               OVF_CLR
`ifdef SAR_COLLECT_CNT_EN
  ,
  output logic [CNT_W-1:0]   WORD_CNT
`endif
);

  localparam int unsigned IDX_W = $clog2(BIT_ADC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_ADC - 1);

  logic               comp_clk_q, comp_clk_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [BIT_ADC-1:0] shift_q, shift_d;
  logic               ovf_q, ovf_d;
  logic               stb_s, push_s, pop_s, drop_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [BIT_ADC-1:0] word_s;

  // Strobe detect plus bit counter / shift register; SYNC overrides any strobe.
  always_comb begin
    comp_clk_d = COMP_CLK;
    stb_s      = comp_clk_q & ~COMP_CLK;
    word_s     = {shift_q[BIT_ADC-2:0], DIGITAL_OUT};
    push_s     = 1'b0;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    if (SYNC) begin
      bit_idx_d = '0;
      shift_d   = '0;
    end else if (stb_s) begin
      shift_d = word_s;
      if (bit_idx_q == LAST_IDX) begin
        bit_idx_d = '0;
        push_s    = 1'b1;
      end else begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end else begin
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
    end
  end

  // Overflow is sticky; a drop in the same cycle as OVF_CLR keeps it set.
  always_comb begin
    pop_s  = ~fifo_empty_s & DATA_READY;
    drop_s = push_s & fifo_full_s & ~pop_s;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      comp_clk_q <= 1'b0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      comp_clk_q <= comp_clk_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SAR_COLLECT_CNT_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    if (push_s & ~drop_s) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign WORD_CNT = word_cnt_q;
`endif

  sar_collect_fifo #(
    .WIDTH (BIT_ADC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .din   (word_s),
    .full  (fifo_full_s),
    .pop   (pop_s),
    .dout  (DATA),
    .empty (fifo_empty_s)
  );

  assign DATA_VALID = ~fifo_empty_s;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_sar_result_collector.sv
// Randomized scoreboard bench for sar_result_collector; the reference model works on
// decision lists and timestamped queue entries. Honors SAR_COLLECT_CNT_EN.
module tb_sar_result_collector;
  import sar_pkg::*;

  localparam int unsigned DEPTH = SAR_FIFO_DEPTH;

  logic       clk = 1'b0;
  logic       rst, comp_clk, dout_bit, sync, ready, ovf_clr;
  logic [7:0] data;
  logic       data_valid, ovf;
`ifdef SAR_COLLECT_CNT_EN
  logic [15:0] word_cnt;
`endif

  always #5 clk = ~clk;

  sar_result_collector dut (
    .CLK         (clk),
    .RST         (rst),
    .COMP_CLK    (comp_clk),
    .DIGITAL_OUT (dout_bit),
    .SYNC        (sync),
    .DATA        (data),
    .DATA_VALID  (data_valid),
    .DATA_READY  (ready),
    .OVF         (ovf),
    .OVF_CLR     (ovf_clr)
`ifdef SAR_COLLECT_CNT_EN
    ,
    .WORD_CNT    (word_cnt)
`endif
  );

  typedef struct {
    logic [7:0] w;
    int         t;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         edge_n   = 0;
  int         nbits    = 0;
  int         m_acc    = 0;
  int         m_cnt    = 0;
  bit         m_prev   = 1'b0;
  bit         m_ovf    = 1'b0;
  bit         m_valid  = 1'b0;
  bit         chk_rst  = 1'b0;
  bit         started  = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is the 8 decisions since the last SYNC/word boundary, weighted
  // MSB first; a stored word becomes visible once one full edge has passed after its push.
  always @(posedge clk) begin : model
    bit stb;
    bit set;
    edge_n++;
    if (rst) begin
      mq.delete();
      sb_q.delete();
      nbits   = 0;
      m_acc   = 0;
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
      m_valid = 1'b0;
      chk_rst = 1'b1;
      started = 1'b1;
    end else begin
      chk_rst = 1'b0;
      if (m_valid && ready) void'(mq.pop_front());
      stb    = m_prev && !comp_clk;
      m_prev = comp_clk;
      set    = 1'b0;
      if (sync) begin
        nbits = 0;
        m_acc = 0;
      end else if (stb) begin
        m_acc = (m_acc * 2 + int'(dout_bit)) % 256;
        nbits++;
        if (nbits == 8) begin
          if (mq.size() < DEPTH) begin
            mq.push_back('{w: 8'(m_acc), t: edge_n});
            sb_q.push_back(8'(m_acc));
            m_cnt++;
          end else begin
            set = 1'b1;
          end
          nbits = 0;
          m_acc = 0;
        end
      end
      if (set) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_valid = (mq.size() > 0) && (mq[0].t < edge_n);
    end
  end

  // Monitor: compares presented outputs each cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin : monitor
    logic [7:0] exp_w;
    if (started) begin
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SAR_COLLECT_CNT_EN
      check("word_cnt", 32'(word_cnt), 32'(m_cnt % 65536));
`endif
      if (chk_rst) check("reset_data", 32'(data), 32'h0);
      if (data_valid === 1'b1 && ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got word %0h expected none", data);
        end else begin
          exp_w = sb_q.pop_front();
          check("data", 32'(data), 32'(exp_w));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b, input int p);
    dout_bit = b;
    comp_clk = 1'b1;
    repeat (p / 2) tick();
    comp_clk = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  // pop_last raises DATA_READY only in the cycle whose edge pushes the final decision.
  task automatic send_word(input logic [7:0] w, input int p, input bit pop_last);
    logic [7:0] v;
    v = w;
    for (int i = 7; i >= 1; i--) send_bit(v[i], p);
    dout_bit = v[0];
    comp_clk = 1'b1;
    repeat (p / 2) tick();
    comp_clk = 1'b0;
    if (pop_last) ready = 1'b1;
    tick();
    if (pop_last) ready = 1'b0;
    repeat (p - p / 2 - 1) tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int drain;
    rst = 1'b1; comp_clk = 1'b0; dout_bit = 1'b0; sync = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single word at the nominal rate, consumer ready
    ready = 1'b1;
    send_word(8'hA5, SAR_PHASES, 1'b0);
    repeat (4) tick();

    // Back-to-back words held, then released in order
    ready = 1'b0;
    send_word(8'h00, 2, 1'b0);
    send_word(8'hFF, 2, 1'b0);
    send_word(8'h5A, 2, 1'b0);
    repeat (3) tick();
    ready = 1'b1;
    repeat (8) tick();

    // Overflow: five words into four slots, then clear
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 2, 1'b0);
    repeat (2) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ready = 1'b1;
    repeat (8) tick();

    // Full buffer, fifth push coincides with a pop
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(8'(8'h11 * (i + 1)), 2, 1'b0);
    repeat (2) tick();
    send_word(8'hC3, 2, 1'b1);
    repeat (2) tick();
    ready = 1'b1;
    repeat (8) tick();

    // Realign after a partial word; strobe coincident with SYNC is discarded
    send_bit(1'b1, SAR_PHASES);
    send_bit(1'b0, SAR_PHASES);
    send_bit(1'b1, SAR_PHASES);
    dout_bit = 1'b1;
    comp_clk = 1'b1;
    tick();
    comp_clk = 1'b0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    send_word(8'h3C, SAR_PHASES, 1'b0);
    repeat (4) tick();

    // Reset mid-word with queued words
    ready = 1'b0;
    send_word(8'h12, 2, 1'b0);
    send_word(8'h34, 2, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b1;
    send_word(8'h81, SAR_PHASES, 1'b0);
    repeat (4) tick();

    // Random traffic with random consumer stalls, SYNC and OVF_CLR pulses
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_bit(1'($urandom), 2);
        sync = 1'b1;
        tick();
        sync = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) begin
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
      end
      send_word(8'($urandom), int'($urandom_range(2, 8)), 1'b0);
    end

    rand_ready = 1'b0;
    ready = 1'b1;
    drain = 0;
    while (sb_q.size() != 0 && drain < 200) begin
      tick();
      drain++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb_q.size());
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
